// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for the FIFO stream reader.
// - State encoding for the reader FSM (2 bits).
// - Lane-index width helper: clog2 of the lane count, never less than 1 bit.
package fifo_stream_reader_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_EMIT  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // A single-lane FIFO still needs a 1-bit index so the vectors stay legal.
    function automatic int unsigned lane_idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_lane_mux.sv
// PAR_READ:1 lane selector for the chunk register.
// Ports:
//   i_lanes  PAR_READ*DATA_WIDTH  packed lanes, lane k at [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
//   i_sel    IDX_W                lane index
//   o_data   DATA_WIDTH           selected lane (0 for an index beyond the last lane)
module fifo_stream_reader_lane_mux #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PAR_READ   = 4,
    parameter int unsigned IDX_W      = 2
) (
    input  logic [PAR_READ*DATA_WIDTH-1:0] i_lanes,
    input  logic [IDX_W-1:0]               i_sel,
    output logic [DATA_WIDTH-1:0]          o_data
);

    always_comb begin
        o_data = '0;
        for (int k = 0; k < int'(PAR_READ); k++) begin
            if (i_sel == IDX_W'(k)) begin
                o_data = i_lanes[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side consumer of the parallel-read FIFO. On start it pops PAR_READ-wide
// chunks and serialises them into a one-element-per-cycle valid/ready stream,
// stopping after the programmed element count and pulsing done.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   i_clear          synchronous abort back to idle (no done pulse)
//   i_start, i_len   begin a transfer of i_len elements (sampled in idle only)
//   i_fifo_dout      FIFO read data, PAR_READ lanes
//   i_fifo_valid     FIFO holds at least one full chunk
//   o_fifo_ren       pop request; a pop happens on o_fifo_ren & i_fifo_valid
//   o_out_data/o_out_valid/i_out_ready  downstream element stream
//   o_busy           high whenever not idle (includes the done cycle)
//   o_done           one-cycle completion pulse
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PAR_READ   = 4,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           i_clear,
    input  logic                           i_start,
    input  logic [LEN_WIDTH-1:0]           i_len,
    input  logic [PAR_READ*DATA_WIDTH-1:0] i_fifo_dout,
    input  logic                           i_fifo_valid,
    output logic                           o_fifo_ren,
    output logic [DATA_WIDTH-1:0]          o_out_data,
    output logic                           o_out_valid,
    input  logic                           i_out_ready,
    output logic                           o_busy,
    output logic                           o_done
);

    localparam int unsigned     IDX_W     = lane_idx_width(PAR_READ);
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(PAR_READ - 1);

    state_t                          r_state, w_state_next;
    logic [PAR_READ*DATA_WIDTH-1:0]  r_chunk, w_chunk_next;
    logic [IDX_W-1:0]                r_lane, w_lane_next;
    logic [LEN_WIDTH-1:0]            r_remaining, w_remaining_next;
    logic                            w_handshake, w_last_elem, w_last_lane;
    logic [DATA_WIDTH-1:0]           w_lane_data;

    assign w_handshake = (r_state == ST_EMIT) && i_out_ready;
    assign w_last_elem = (r_remaining == LEN_WIDTH'(1));
    assign w_last_lane = (r_lane == LAST_LANE);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_chunk     <= '0;
            r_lane      <= '0;
            r_remaining <= '0;
        end else begin
            r_chunk     <= w_chunk_next;
            r_lane      <= w_lane_next;
            r_remaining <= w_remaining_next;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_next     = r_state;
        w_chunk_next     = r_chunk;
        w_lane_next      = r_lane;
        w_remaining_next = r_remaining;
        if (i_clear) begin
            w_state_next     = ST_IDLE;
            w_chunk_next     = '0;
            w_lane_next      = '0;
            w_remaining_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_len != '0) begin
                            w_remaining_next = i_len;
                            w_lane_next      = '0;
                            w_state_next     = ST_FETCH;
                        end else begin
                            w_state_next = ST_DONE;
                        end
                    end
                end
                ST_FETCH: begin
                    if (i_fifo_valid) begin
                        w_chunk_next = i_fifo_dout;
                        w_lane_next  = '0;
                        w_state_next = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (w_handshake) begin
                        w_remaining_next = r_remaining - LEN_WIDTH'(1);
                        if (w_last_elem) begin
                            // Leftover lanes of a partial final chunk are dropped here.
                            w_state_next = ST_DONE;
                        end else if (w_last_lane) begin
                            // Pop issued this cycle: reload without a bubble if data is there.
                            if (i_fifo_valid) begin
                                w_chunk_next = i_fifo_dout;
                                w_lane_next  = '0;
                            end else begin
                                w_state_next = ST_FETCH;
                            end
                        end else begin
                            w_lane_next = r_lane + IDX_W'(1);
                        end
                    end
                end
                ST_DONE:  w_state_next = ST_IDLE;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        o_fifo_ren  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = (r_state != ST_IDLE);
        o_done      = (r_state == ST_DONE);
        case (r_state)
            ST_FETCH: o_fifo_ren = !i_clear;
            ST_EMIT: begin
                o_out_valid = 1'b1;
                o_fifo_ren  = w_handshake && !w_last_elem && w_last_lane && !i_clear;
            end
            default: ;
        endcase
    end

    fifo_stream_reader_lane_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .PAR_READ   (PAR_READ),
        .IDX_W      (IDX_W)
    ) u_lane_mux (
        .i_lanes (r_chunk),
        .i_sel   (r_lane),
        .o_data  (w_lane_data)
    );

    assign o_out_data = w_lane_data;

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Consumer on the read side of the parallel-read FIFO.
- On start, pops PAR_READ-wide chunks through the FIFO's ren/valid handshake and serialises them into a one-element-per-cycle valid/ready stream for the downstream datapath.
- Stops after a programmed element count and pulses done.
- Sits between the FIFO read port and the compute unit's input.

Parameters:
- DATA_WIDTH, 8, bits per element.
- PAR_READ, 4, elements per FIFO pop; must match the FIFO's PAR_READ and be ≥1.
- LEN_WIDTH, 16, width of the transfer-length input and remaining-element counter.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- clear  in  1  synchronous abort
- start  in  1  begin transfer; sampled in IDLE only
- len  in  LEN_WIDTH  element count, latched on accepted start
- fifo_dout  in  PAR_READ*DATA_WIDTH  FIFO read data; lane k = bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
- fifo_valid  in  1  FIFO holds ≥PAR_READ elements
- fifo_ren  out  1  pop request; a pop occurs when fifo_ren & fifo_valid
- out_data  out  DATA_WIDTH  streamed element
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- busy  out  1  high from accepted start until done, inclusive
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk.
  - Reset forces state IDLE, chunk register 0, lane index 0, remaining 0.
  - Reset value of every output is 0.
- FSM states: IDLE, FETCH, EMIT, DONE.
- IDLE:
  - start=1 and len≠0: latch remaining=len, lane index=0, go to FETCH.
  - start=1 and len=0: go to DONE.
  - start outside IDLE is ignored.
- FETCH:
  - fifo_ren=1.
  - When fifo_valid=1: capture fifo_dout into the chunk register, lane index=0, go to EMIT.
  - Otherwise wait; no timeout.
- EMIT:
  - out_valid=1, out_data=chunk lane[lane index], lane 0 first.
  - out_data is held stable while out_valid & ~out_ready.
  - On handshake (out_valid & out_ready): remaining decrements by 1.
    - If remaining was 1: go to DONE; unused lanes of the chunk are discarded and never re-read.
    - Else if lane index = PAR_READ-1 (last lane of the chunk):
      - assert fifo_ren combinationally in that same cycle;
      - if fifo_valid=1: load the new chunk, lane index=0, stay in EMIT (zero-bubble back-to-back);
      - else go to FETCH.
    - Else: lane index increments.
- fifo_ren must never be asserted in IDLE or DONE, nor in EMIT except on the last-lane handshake described above.
  - fifo_ren is combinational from state, out_ready, lane index and remaining.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. A start in DONE is ignored.
- busy = (state ≠ IDLE).
- Partial final chunk: if len mod PAR_READ ≠ 0, the last pop delivers extra lanes that are dropped. Exactly ceil(len/PAR_READ) pops per transfer.
- clear:
  - synchronous; highest priority after rstn;
  - returns to IDLE with counters zeroed and no done pulse;
  - fifo_ren=0 in the clear cycle;
  - an in-flight chunk is lost. The FIFO is cleared by the same system clear.
- Width rules:
  - lane index is max(1, clog2(PAR_READ)) bits and wraps only via an explicit reset to 0;
  - remaining is LEN_WIDTH bits and never underflows (the transition out of EMIT happens at 1).
- Throughput: 1 element/cycle sustained when fifo_valid and out_ready stay high. First out_valid appears 2 cycles after the start cycle.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE, ST_FETCH, ST_EMIT, ST_DONE (2 bits);
  - lane-index width function (clog2 with a minimum of 1).
- One sub-module is natural: lane_mux (PAR_READ:1 DATA_WIDTH multiplexer selecting a lane by index).
- FSM and counters stay in the top.

Test Plan:
- PAR_READ=4, DATA_WIDTH=8, FIFO preloaded with 0x00..0x07, out_ready=1, start with len=8:
  - out_data 0x00..0x07 on 8 consecutive cycles;
  - exactly 2 pops with no bubble between 0x03 and 0x04;
  - done pulse the cycle after 0x07.
- len=6, FIFO holds 0x10..0x17:
  - emits 0x10..0x15 then done;
  - 2 pops total; 0x16/0x17 never appear.
- len=0 start:
  - done one cycle later;
  - fifo_ren never asserted; out_valid stays 0.
- Backpressure:
  - out_ready toggles 1,0,0,1,...;
  - out_data is held stable while stalled;
  - element order and count are unchanged;
  - no pop occurs during a stall on lane 3.
- FIFO starvation:
  - fifo_valid=0 after the first chunk: FSM waits in FETCH with fifo_ren=1 and out_valid=0;
  - raising fifo_valid resumes with the next element.
- clear mid-EMIT at lane 2 of len=8:
  - next cycle IDLE, busy=0, no done pulse;
  - a following start with len=4 streams fresh data correctly.
- rstn asserted mid-transfer:
  - all outputs 0 immediately;
  - restart after release behaves as first use.
